xclk_status_tx: RTL and testbench
=================================

# xclk_status_tx

Transmitting end of a four-phase req/ack clock-domain crossing that carries a WIDTH-bit status word from the out_clk core domain to the PCIe-side clock domain. It is the counterpart of the bit synchronizers that bring host-side levels into out_clk. The block gates acceptance on the debounced PLL lock indication and holds data stable for the whole handshake. It synchronizes the returning acknowledge internally and reports stalled handshakes.

## Interface
Parameters:
- WIDTH, 8, status word width
- SETUP_CYCLES, 1, cycles xdata is stable before xreq rises (1..15)
- TIMEOUT, 1024, max cycles in REQ awaiting ack before abort (≥4)

Ports:
- out_clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- locked  in  1  PLL-stable indication (out_clk domain)
- stat_valid  in  1  source offers stat_data
- stat_data  in  WIDTH  status word
- stat_ready  out  1  block accepts on stat_valid & stat_ready
- xreq  out  1  request to far domain, registered, glitch-free
- xdata  out  WIDTH  crossing data, registered; stable while xreq=1 and during setup
- xack  in  1  acknowledge from far domain, asynchronous
- busy  out  1  handshake in progress (state ≠ IDLE)
- err  out  1  sticky timeout flag; cleared only by rst
- xfer_count  out  16  completed handshakes, wraps 0xFFFF→0

## Operation
- Reset values: xreq=0, xdata=0, stat_ready=0, busy=0, err=0, xfer_count=0, state=IDLE, ack synchronizer=00.
- xack passes through a 2-flop synchronizer to ack_s. The FSM never uses raw xack.
- States:
  - IDLE: stat_ready=locked. On accept, xdata←stat_data, setup counter←0, go SETUP.
  - SETUP: count. After SETUP_CYCLES cycles, xreq←1, timeout counter←0, go REQ.
  - REQ: if ack_s=1: xreq←0, go DROP. Else, if the timeout counter reaches TIMEOUT-1: err←1, xreq←0, go DROP.
  - DROP: wait ack_s=0, then go IDLE. xfer_count increments on the DROP→IDLE transition, except after a timeout.
- The ack_s=1 check takes priority over timeout on the same cycle.
- locked falling mid-transfer: the handshake completes normally and no new accept occurs until locked=1 again. The four-phase protocol is never truncated by lock loss.
- Entering SETUP with ack_s still 1 is impossible because DROP guarantees ack_s=0.
- rst mid-handshake: xreq drops asynchronously. The far side sees req fall and must tolerate it.

## Timing
- Accept at edge N → xdata updated after N. xreq=1 after edge N+SETUP_CYCLES+1.
- xack rising at edge M, with setup met → ack_s=1 after M+2. xreq=0 after M+3.
- xack falling at edge K → state IDLE after K+3. stat_ready=1 the same cycle if locked.
- Minimum transfer period with zero-latency far side and SETUP_CYCLES=1: 1 setup + 1 + 3 + 3 ≈ 8 cycles.
- stat_ready is combinational from state and locked. No combinational path from stat_valid to stat_ready.

## Configuration
- XCLK_TX_COALESCE_EN defined:
  - stat_ready=locked in every state.
  - One pending register with a valid flag. Accepts while busy overwrite the pending word (newest wins).
  - In DROP, when ack_s=0 and pending is valid: load xdata from pending, clear the flag, go SETUP directly without visiting IDLE.
  - An accept in the same cycle as the pending load goes to pending.
  - A 16-bit coalesce_count output counts overwrites of an already-valid pending word, reset 0 and wrapping.
- Undefined: no pending register, no coalesce_count port, stat_ready=0 whenever busy.

## Structure
- Package xclk_pkg: state enum typedef (IDLE, SETUP, REQ, DROP) and the localparam XCLK_SYNC_STAGES=2.
- Sub-module bit_sync: parameterized-depth single-bit synchronizer with async reset, used for xack.
- Counters sized with $clog2 of SETUP_CYCLES+1 and TIMEOUT.

## Test plan
- Basic transfer: locked=1, accept 0xA5. The bench acks 4 cycles after xreq rises and deasserts 4 cycles after xreq falls. Expect xdata=0xA5 throughout, xreq pulse per the Timing rules, xfer_count=1, err=0.
- Lock gating: locked=0 with stat_valid=1 → stat_ready=0 and no xreq. Raise locked → accept on the next edge.
- Lock loss mid-handshake: drop locked while in REQ → the handshake completes, xfer_count increments, and stat_ready stays 0 until locked=1.
- Timeout: TIMEOUT=16 with xack held 0 → xreq falls exactly 16 cycles after rising, err=1 sticky, xfer_count unchanged. The next transfer still works.
- Reset mid-operation: assert rst in SETUP and in REQ → all outputs return to reset values immediately. Normal operation follows after release.
- With XCLK_TX_COALESCE_EN: send 0x01, then 0x02 and 0x03 while busy → exactly two far-side transfers carrying 0x01 and 0x03, with coalesce_count=1.

Source files
------------

// File: rtl/xclk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xclk_pkg
// Purpose  : Shared types and constants for the xclk status transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package xclk_pkg;

    // Depth of the synchronizer on the returning acknowledge
    localparam int XCLK_SYNC_STAGES = 2;

    // Four-phase handshake state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        DROP  = 2'd3
    } xclk_state_t;

endpackage
`default_nettype wire

// File: rtl/xclk_status_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : xclk_status_tx_if
// Purpose  : Source-side valid/ready bus and far-side req/ack/data bundle
//            for the xclk status transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface xclk_status_tx_if #(
    parameter int WIDTH = 8
);
    logic             stat_valid;
    logic [WIDTH-1:0] stat_data;
    logic             stat_ready;
    logic             xreq;
    logic [WIDTH-1:0] xdata;
    logic             xack;

    // master: the transmitter itself
    modport master (
        input  stat_valid, stat_data, xack,
        output stat_ready, xreq, xdata
    );

    // slave: the status source and the far-domain receiver
    modport slave (
        output stat_valid, stat_data, xack,
        input  stat_ready, xreq, xdata
    );
endinterface
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : bit_sync
// Purpose  : Single-bit multi-flop synchronizer with asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module bit_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/xclk_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : xclk_status_tx
// Purpose  : Transmitting end of a four-phase req/ack crossing that carries
//            a status word out of the out_clk domain. Acceptance is gated by
//            PLL lock, data is held for the whole handshake, stalled
//            handshakes are aborted and flagged.
// Options  : XCLK_TX_COALESCE_EN - one-deep pending register, newest wins,
//            adds the coalesce_count port.
// Revision : 1.0 - initial release
// ============================================================================
module xclk_status_tx
    import xclk_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int TIMEOUT      = 1024
) (
    input  wire logic        out_clk,
    input  wire logic        rst,
    input  wire logic        locked,
    xclk_status_tx_if.master bus,
    output logic             busy,
    output logic             err,
    output logic [15:0]      xfer_count
`ifdef XCLK_TX_COALESCE_EN
    ,
    output logic [15:0]      coalesce_count
`endif
);

    localparam int SW = (SETUP_CYCLES > 0) ? $clog2(SETUP_CYCLES + 1) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] C_SETUP_LAST = SW'(SETUP_CYCLES);
    localparam logic [TW-1:0] C_TO_LAST    = TW'(TIMEOUT - 1);

    xclk_state_t      r_state;
    logic             r_xreq;
    logic [WIDTH-1:0] r_xdata;
    logic [SW-1:0]    r_setup_cnt;
    logic [TW-1:0]    r_to_cnt;
    logic             r_err;
    logic             r_abort;
    logic [15:0]      r_xfer_cnt;

    logic             w_ack_s;
    logic             w_accept;
    logic             w_start;
    logic [WIDTH-1:0] w_start_data;

    bit_sync #(
        .STAGES (XCLK_SYNC_STAGES)
    ) u_ack_sync (
        .clk (out_clk),
        .rst (rst),
        .i_d (bus.xack),
        .o_q (w_ack_s)
    );

`ifdef XCLK_TX_COALESCE_EN
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_vld;
    logic [15:0]      r_coal_cnt;
    logic             w_pend_take;
    logic             w_to_pend;

    // The source may offer a word at any time while locked; busy words park
    assign bus.stat_ready = locked & ~rst;
    assign w_accept       = bus.stat_valid & bus.stat_ready;
    // A parked word launches ahead of a fresh offer
    assign w_start        = r_pend_vld | w_accept;
    assign w_start_data   = r_pend_vld ? r_pend : bus.stat_data;
    assign w_pend_take    = r_pend_vld &
                            ((r_state == IDLE) | ((r_state == DROP) & ~w_ack_s));
    // Anything not launching straight from IDLE goes to the pending slot
    assign w_to_pend      = w_accept & ((r_state != IDLE) | r_pend_vld);

    // Pending slot: newest word wins, overwrites of an unsent word are counted
    always_ff @(posedge out_clk or posedge rst) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_coal_cnt <= '0;
        end else if (w_to_pend) begin
            r_pend     <= bus.stat_data;
            r_pend_vld <= 1'b1;
            if (r_pend_vld && !w_pend_take) begin
                r_coal_cnt <= r_coal_cnt + 16'd1;
            end
        end else if (w_pend_take) begin
            r_pend_vld <= 1'b0;
        end
    end

    assign coalesce_count = r_coal_cnt;
`else
    // Only an idle transmitter accepts, and only while the PLL is locked
    assign bus.stat_ready = locked & ~rst & (r_state == IDLE);
    assign w_accept       = bus.stat_valid & bus.stat_ready;
    assign w_start        = w_accept;
    assign w_start_data   = bus.stat_data;
`endif

    // Handshake FSM; xreq and xdata are driven straight from flops
    always_ff @(posedge out_clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_xreq      <= 1'b0;
            r_xdata     <= '0;
            r_setup_cnt <= '0;
            r_to_cnt    <= '0;
            r_err       <= 1'b0;
            r_abort     <= 1'b0;
            r_xfer_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_xdata     <= w_start_data;
                        r_setup_cnt <= '0;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_setup_cnt == C_SETUP_LAST) begin
                        r_xreq   <= 1'b1;
                        r_to_cnt <= '0;
                        r_state  <= REQ;
                    end else begin
                        r_setup_cnt <= r_setup_cnt + 1'b1;
                    end
                end
                REQ: begin
                    // A real acknowledge wins over an expiring timer
                    if (w_ack_s) begin
                        r_xreq  <= 1'b0;
                        r_state <= DROP;
                    end else if (r_to_cnt == C_TO_LAST) begin
                        r_err   <= 1'b1;
                        r_abort <= 1'b1;
                        r_xreq  <= 1'b0;
                        r_state <= DROP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                DROP: begin
                    // Leaving DROP closes a handshake; aborted ones are not counted
                    if (!w_ack_s) begin
                        if (!r_abort) begin
                            r_xfer_cnt <= r_xfer_cnt + 16'd1;
                        end
                        r_abort <= 1'b0;
`ifdef XCLK_TX_COALESCE_EN
                        if (r_pend_vld) begin
                            r_xdata     <= r_pend;
                            r_setup_cnt <= '0;
                            r_state     <= SETUP;
                        end else begin
                            r_state <= IDLE;
                        end
`else
                        r_state <= IDLE;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.xreq   = r_xreq;
    assign bus.xdata  = r_xdata;
    assign busy       = (r_state != IDLE);
    assign err        = r_err;
    assign xfer_count = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_xclk_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_xclk_status_tx
// Purpose  : Self-checking bench for xclk_status_tx (SETUP_CYCLES=1,
//            TIMEOUT=16). Build with XCLK_TX_COALESCE_EN for the coalesce
//            sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xclk_status_tx;

    localparam int WIDTH        = 8;
    localparam int SETUP_CYCLES = 1;
    localparam int TIMEOUT      = 16;
`ifdef XCLK_TX_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        out_clk = 1'b0;
    logic        rst;
    logic        locked;
    logic        busy;
    logic        err;
    logic [15:0] xfer_count;
`ifdef XCLK_TX_COALESCE_EN
    logic [15:0] coalesce_count;
`endif

    xclk_status_tx_if #(.WIDTH(WIDTH)) bus ();

    xclk_status_tx #(
        .WIDTH        (WIDTH),
        .SETUP_CYCLES (SETUP_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .out_clk        (out_clk),
        .rst            (rst),
        .locked         (locked),
        .bus            (bus),
        .busy           (busy),
        .err            (err),
        .xfer_count     (xfer_count)
`ifdef XCLK_TX_COALESCE_EN
        ,
        .coalesce_count (coalesce_count)
`endif
    );

    always #5 out_clk = ~out_clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  data;
        int          ack_dly;
        bit          no_ack;
        int          exp_fall;
        int          exp_idle;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge out_clk);
        #1;
    endtask

    // Offer one word while idle and confirm it is taken on the next edge
    task automatic do_accept(input logic [7:0] d);
        bus.stat_valid = 1'b1;
        bus.stat_data  = d;
        #0;
        check("ready_before_accept", {31'd0, bus.stat_ready}, 32'd1);
        tick();
        bus.stat_valid = 1'b0;
        check("xdata_after_accept", {24'd0, bus.xdata}, {24'd0, d});
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Play the far side of one handshake and measure its phases in cycles
    task automatic do_finish(input logic [7:0] d, input int ack_dly, input bit no_ack,
                             input bit drop_lock,
                             output int setup_n, output int fall_n, output int idle_n);
        bit stable;
        stable  = 1'b1;
        setup_n = -1;
        fall_n  = -1;
        idle_n  = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.xreq) begin
                setup_n = i;
                break;
            end
        end
        if (drop_lock) locked = 1'b0;
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            if (bus.xdata !== d) stable = 1'b0;
        end
        if (!no_ack) bus.xack = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.xreq && bus.xdata !== d) stable = 1'b0;
            if (!bus.xreq) begin
                fall_n = ack_dly + i;
                break;
            end
        end
        check("xdata_stable", {31'd0, stable}, 32'd1);
        if (!no_ack) begin
            for (int i = 0; i < 4; i++) tick();
            bus.xack = 1'b0;
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!busy) begin
                idle_n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s_n, f_n, i_n;
        int n_seen;
        bit done;
        logic [7:0] seen[2];

        vecs[0] = '{8'hA5, 4, 1'b0,  7, 3, 1'b0, 16'd1};
        vecs[1] = '{8'h3C, 0, 1'b0,  3, 3, 1'b0, 16'd2};
        vecs[2] = '{8'hFF, 2, 1'b0,  5, 3, 1'b0, 16'd3};
        vecs[3] = '{8'h5A, 0, 1'b1, 16, 1, 1'b1, 16'd3};
        vecs[4] = '{8'h81, 1, 1'b0,  4, 3, 1'b1, 16'd4};

        rst            = 1'b1;
        locked         = 1'b0;
        bus.xack       = 1'b0;
        bus.stat_valid = 1'b0;
        bus.stat_data  = '0;
        tick();
        tick();
        check("rst_xreq",   {31'd0, bus.xreq}, 32'd0);
        check("rst_xdata",  {24'd0, bus.xdata}, 32'd0);
        check("rst_ready",  {31'd0, bus.stat_ready}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_err",    {31'd0, err}, 32'd0);
        check("rst_count",  {16'd0, xfer_count}, 32'd0);
        rst = 1'b0;
        tick();
        locked = 1'b1;

        // Table-driven transfers: normal, immediate ack, timeout, recovery
        for (int v = 0; v < 5; v++) begin
            do_accept(vecs[v].data);
            do_finish(vecs[v].data, vecs[v].ack_dly, vecs[v].no_ack, 1'b0, s_n, f_n, i_n);
            check("setup_latency", s_n, 32'd2);
            check("req_width",     f_n, vecs[v].exp_fall);
            check("drop_to_idle",  i_n, vecs[v].exp_idle);
            check("err_flag",      {31'd0, err}, {31'd0, vecs[v].exp_err});
            check("xfer_count",    {16'd0, xfer_count}, {16'd0, vecs[v].exp_cnt});
            check("ready_in_idle", {31'd0, bus.stat_ready}, 32'd1);
        end

        // Lock gating: offer held while unlocked is ignored
        locked         = 1'b0;
        bus.stat_valid = 1'b1;
        bus.stat_data  = 8'h77;
        #0;
        check("gate_ready_unlocked", {31'd0, bus.stat_ready}, 32'd0);
        tick(); tick(); tick();
        check("gate_busy_unlocked", {31'd0, busy}, 32'd0);
        check("gate_xreq_unlocked", {31'd0, bus.xreq}, 32'd0);
        locked = 1'b1;
        #0;
        check("gate_ready_locked", {31'd0, bus.stat_ready}, 32'd1);
        tick();
        bus.stat_valid = 1'b0;
        check("gate_busy_after", {31'd0, busy}, 32'd1);
        check("gate_xdata_after", {24'd0, bus.xdata}, 32'h77);
        check("gate_ready_busy", {31'd0, bus.stat_ready}, {31'd0, COAL});
        do_finish(8'h77, 1, 1'b0, 1'b0, s_n, f_n, i_n);
        check("gate_req_width", f_n, 32'd4);
        check("gate_count", {16'd0, xfer_count}, 32'd5);

        // Lock lost while in REQ: the handshake still completes
        do_accept(8'h42);
        do_finish(8'h42, 2, 1'b0, 1'b1, s_n, f_n, i_n);
        check("loss_req_width", f_n, 32'd5);
        check("loss_count", {16'd0, xfer_count}, 32'd6);
        check("loss_busy", {31'd0, busy}, 32'd0);
        check("loss_ready", {31'd0, bus.stat_ready}, 32'd0);
        bus.stat_valid = 1'b1;
        bus.stat_data  = 8'h99;
        tick(); tick();
        check("loss_no_accept", {31'd0, busy}, 32'd0);
        check("loss_xdata_held", {24'd0, bus.xdata}, 32'h42);
        locked = 1'b1;
        #0;
        check("loss_ready_relock", {31'd0, bus.stat_ready}, 32'd1);
        tick();
        bus.stat_valid = 1'b0;
        check("loss_xdata_new", {24'd0, bus.xdata}, 32'h99);
        do_finish(8'h99, 0, 1'b0, 1'b0, s_n, f_n, i_n);
        check("loss_count2", {16'd0, xfer_count}, 32'd7);

        // Reset while in SETUP
        do_accept(8'h11);
        rst = 1'b1;
        #1;
        check("rsetup_xreq",  {31'd0, bus.xreq}, 32'd0);
        check("rsetup_busy",  {31'd0, busy}, 32'd0);
        check("rsetup_xdata", {24'd0, bus.xdata}, 32'd0);
        check("rsetup_err",   {31'd0, err}, 32'd0);
        check("rsetup_count", {16'd0, xfer_count}, 32'd0);
        check("rsetup_ready", {31'd0, bus.stat_ready}, 32'd0);
        tick();
        rst = 1'b0;

        // Reset while in REQ
        do_accept(8'h22);
        for (int i = 0; i < 20 && !bus.xreq; i++) tick();
        check("rreq_xreq_up", {31'd0, bus.xreq}, 32'd1);
        rst = 1'b1;
        #1;
        check("rreq_xreq",  {31'd0, bus.xreq}, 32'd0);
        check("rreq_busy",  {31'd0, busy}, 32'd0);
        check("rreq_xdata", {24'd0, bus.xdata}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        do_accept(8'hC3);
        do_finish(8'hC3, 1, 1'b0, 1'b0, s_n, f_n, i_n);
        check("post_rst_width", f_n, 32'd4);
        check("post_rst_count", {16'd0, xfer_count}, 32'd1);
        check("post_rst_err",   {31'd0, err}, 32'd0);

`ifdef XCLK_TX_COALESCE_EN
        // Two offers while busy collapse into one, newest wins
        do_accept(8'h01);
        bus.stat_valid = 1'b1;
        bus.stat_data  = 8'h02;
        tick();
        bus.stat_data  = 8'h03;
        tick();
        bus.stat_valid = 1'b0;
        check("coal_count_early", {16'd0, coalesce_count}, 32'd1);
        n_seen = 0;
        done   = 1'b0;
        seen[0] = '0;
        seen[1] = '0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (bus.xreq && !bus.xack) begin
                if (n_seen < 2) seen[n_seen] = bus.xdata;
                n_seen++;
                bus.xack = 1'b1;
            end else if (!bus.xreq && bus.xack) begin
                bus.xack = 1'b0;
            end
            if (!busy && !bus.xack && i > 2) done = 1'b1;
        end
        check("coal_finished", {31'd0, done}, 32'd1);
        check("coal_n_xfers", n_seen, 32'd2);
        check("coal_first",   {24'd0, seen[0]}, 32'h01);
        check("coal_second",  {24'd0, seen[1]}, 32'h03);
        check("coal_count",   {16'd0, coalesce_count}, 32'd1);
        check("coal_xfer_count", {16'd0, xfer_count}, 32'd3);
`else
        n_seen = 0;
        done   = 1'b0;
        seen[0] = '0;
        seen[1] = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
